// File: rtl/video_timing_meas.sv
// video_timing_meas: measures active width and line count of incoming video,
// commits them on each frame sync and flags stability, mismatch and loss.
module video_timing_meas #(
  parameter logic        VS_POL        = 1'b1,
  parameter int          STABLE_FRAMES = 3,
  parameter logic [23:0] FRAME_TIMEOUT = 24'd4000000
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        v_sync,
  input  logic        d_en,
  output logic [11:0] active_width,
  output logic [10:0] line_num,
  output logic        meas_valid,
  output logic        width_mismatch,
  output logic        overflow,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_WAIT_VS,
    S_MEASURE,
    S_LOCKED
  } state_t;

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  state_t      state_q;
  logic        vs_d1_q, vs_d2_q;
  logic        de_d1_q, de_d2_q;
  logic [11:0] wcnt_q, wcnt_d;
  logic [11:0] ref_q, ref_d;
  logic [10:0] lcnt_q, lcnt_d;
  logic        mm_q, mm_d;
  logic        ovf_q, ovf_d;
  logic [23:0] tcnt_q, tcnt_d;
  logic [3:0]  stab_q, stab_d;
  logic [11:0] aw_q, aw_d;
  logic [10:0] ln_q;
  logic        valid_q, wmm_q, ovo_q, to_q;
  logic        vs_lead, de_rise, de_fall;
  logic        clean, same, to_hit;

  assign vs_lead = (vs_d1_q == VS_POL) && (vs_d2_q != VS_POL);
  assign de_rise = de_d1_q & ~de_d2_q;
  assign de_fall = ~de_d1_q & de_d2_q;

  assign active_width   = aw_q;
  assign line_num       = ln_q;
  assign meas_valid     = valid_q;
  assign width_mismatch = wmm_q;
  assign overflow       = ovo_q;
  assign timeout        = to_q;

  // Frame accumulators advanced by this cycle's pixel/line events.
  always_comb begin
    wcnt_d = wcnt_q;
    ref_d  = ref_q;
    lcnt_d = lcnt_q;
    mm_d   = mm_q;
    ovf_d  = ovf_q;
    if (de_rise) begin
      wcnt_d = 12'd1;
    end else if (de_d1_q) begin
      if (wcnt_q == 12'hFFF) ovf_d = 1'b1;
      else wcnt_d = wcnt_q + 12'd1;
    end
    if (de_fall) begin
      if (lcnt_q == 11'd0) ref_d = wcnt_q;
      else if (wcnt_q != ref_q) mm_d = 1'b1;
      if (lcnt_q == 11'h7FF) ovf_d = 1'b1;
      else lcnt_d = lcnt_q + 11'd1;
    end
  end

  // Commit candidate, stability count and timeout detection.
  always_comb begin
    aw_d   = (lcnt_d == 11'd0) ? 12'd0 : ref_d;
    clean  = !mm_d && !ovf_d;
    same   = (aw_d == aw_q) && (lcnt_d == ln_q);
    stab_d = 4'd0;
    if (clean) begin
      if (!same) stab_d = 4'd1;
      else if (stab_q == 4'hF) stab_d = 4'hF;
      else stab_d = stab_q + 4'd1;
    end
    tcnt_d = (tcnt_q >= FRAME_TIMEOUT) ? tcnt_q : tcnt_q + 24'd1;
    to_hit = !vs_lead && (tcnt_d >= FRAME_TIMEOUT);
  end

  // Input sync, frame counting, commit FSM and registered outputs.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q <= S_WAIT_VS;
      vs_d1_q <= 1'b0;
      vs_d2_q <= 1'b0;
      de_d1_q <= 1'b0;
      de_d2_q <= 1'b0;
      wcnt_q  <= '0;
      ref_q   <= '0;
      lcnt_q  <= '0;
      mm_q    <= 1'b0;
      ovf_q   <= 1'b0;
      tcnt_q  <= '0;
      stab_q  <= '0;
      aw_q    <= '0;
      ln_q    <= '0;
      valid_q <= 1'b0;
      wmm_q   <= 1'b0;
      ovo_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      vs_d1_q <= v_sync;
      vs_d2_q <= vs_d1_q;
      de_d1_q <= d_en;
      de_d2_q <= de_d1_q;
      wcnt_q  <= wcnt_d;
      if (vs_lead) begin
        ref_q  <= '0;
        lcnt_q <= '0;
        mm_q   <= 1'b0;
        ovf_q  <= 1'b0;
        tcnt_q <= '0;
        to_q   <= 1'b0;
        if (state_q == S_WAIT_VS) begin
          state_q <= S_MEASURE;
        end else begin
          aw_q    <= aw_d;
          ln_q    <= lcnt_d;
          wmm_q   <= mm_d;
          ovo_q   <= ovf_d;
          stab_q  <= stab_d;
          valid_q <= (stab_d >= SF);
          state_q <= (stab_d >= SF) ? S_LOCKED : S_MEASURE;
        end
      end else begin
        ref_q  <= ref_d;
        lcnt_q <= lcnt_d;
        mm_q   <= mm_d;
        ovf_q  <= ovf_d;
        tcnt_q <= tcnt_d;
        if (to_hit) begin
          state_q <= S_WAIT_VS;
          aw_q    <= '0;
          ln_q    <= '0;
          valid_q <= 1'b0;
          stab_q  <= '0;
          wmm_q   <= 1'b0;
          ovo_q   <= 1'b0;
          to_q    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_meas.sv
// tb_video_timing_meas: randomized frames checked against an event-level
// model of committed width/line measurements.
module tb_video_timing_meas;

  localparam logic VS_POL = 1'b1;
  localparam int   SF     = 3;
  localparam int   TO     = 1000;
  localparam int   NCYC   = 32768;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        v_sync = ~VS_POL;
  logic        d_en = 1'b0;
  logic [11:0] active_width;
  logic [10:0] line_num;
  logic        meas_valid, width_mismatch, overflow, timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_e = 0;
  bit s_vs [NCYC];
  bit s_de [NCYC];

  video_timing_meas #(
    .VS_POL(VS_POL),
    .STABLE_FRAMES(SF),
    .FRAME_TIMEOUT(24'(TO))
  ) dut (
    .clock(clk),
    .n_reset(n_reset),
    .v_sync(v_sync),
    .d_en(d_en),
    .active_width(active_width),
    .line_num(line_num),
    .meas_valid(meas_valid),
    .width_mismatch(width_mismatch),
    .overflow(overflow),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] outs();
    return {active_width, line_num, meas_valid,
            width_mismatch, overflow, timeout};
  endfunction

  // Reference: derive sync edges and d_en runs from the sampled history,
  // then close frames between sync edges using the measurement rules.
  function automatic logic [26:0] predict(input int e);
    int lead[$];
    int ra[$];
    int rb[$];
    int rf[$];
    int a, anchor, p, cnt, w, lo, hi, st;
    bit in_run, armed, mmf, ovf, clean, same;
    bit val, mmo, ovo, to;
    logic [11:0] aw, naw, rw;
    logic [10:0] ln, nln;
    a = 0;
    in_run = 0;
    for (int c = rst_e + 2; c <= e; c++)
      if (s_vs[c-1] && !s_vs[c-2]) lead.push_back(c);
    for (int t = rst_e; t < e; t++) begin
      if (s_de[t] && !in_run) begin
        in_run = 1;
        a = t;
      end else if (!s_de[t] && in_run) begin
        in_run = 0;
        ra.push_back(a);
        rb.push_back(t - 1);
        rf.push_back(t + 1);
      end
    end
    if (in_run) begin
      ra.push_back(a);
      rb.push_back(e - 1);
      rf.push_back(32'h7fffffff);
    end
    aw = 0; ln = 0; val = 0; mmo = 0; ovo = 0; to = 0;
    st = 0; armed = 0; anchor = rst_e; p = rst_e;
    foreach (lead[i]) begin
      if (lead[i] - anchor > TO) begin
        aw = 0; ln = 0; val = 0; mmo = 0; ovo = 0;
        st = 0; to = 1; armed = 0;
      end
      if (armed) begin
        cnt = 0; mmf = 0; ovf = 0; rw = 0;
        foreach (ra[j]) begin
          lo = ra[j] + 4096;
          hi = rb[j] + 1;
          if (lo <= hi && lo <= lead[i] && hi > p) ovf = 1;
          if (rf[j] > p && rf[j] <= lead[i]) begin
            w = rb[j] - ra[j] + 1;
            if (w > 4095) w = 4095;
            if (cnt == 0) rw = 12'(w);
            else if (12'(w) != rw) mmf = 1;
            cnt++;
          end
        end
        if (cnt > 2047) begin
          cnt = 2047;
          ovf = 1;
        end
        nln = 11'(cnt);
        naw = (cnt == 0) ? 12'd0 : rw;
        clean = !mmf && !ovf;
        same = (naw == aw) && (nln == ln);
        if (!clean) st = 0;
        else if (!same) st = 1;
        else if (st < 15) st = st + 1;
        aw = naw; ln = nln; mmo = mmf; ovo = ovf;
        val = (st >= SF);
      end
      armed = 1; to = 0; anchor = lead[i]; p = lead[i];
    end
    if (e - anchor >= TO) begin
      aw = 0; ln = 0; val = 0; mmo = 0; ovo = 0; to = 1;
    end
    return {aw, ln, val, mmo, ovo, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!n_reset) begin
      s_vs[cyc] = 0;
      s_de[cyc] = 0;
      rst_e = cyc;
    end else begin
      s_vs[cyc] = (v_sync == VS_POL);
      s_de[cyc] = d_en;
    end
    #1;
  endtask

  task automatic drive_frame(
    input  int          nl,
    input  int          w,
    input  int          bad_line,
    input  int          bad_w,
    input  bit          abut,
    output logic [26:0] o_pre,
    output logic [26:0] x_pre,
    output logic [26:0] o_post,
    output logic [26:0] x_post,
    output int          c_edge
  );
    int vsw, porch, gap;
    vsw = $urandom_range(2, 4);
    porch = $urandom_range(2, 6);
    gap = $urandom_range(2, 8);
    v_sync = VS_POL;
    d_en = 1'b0;
    tick();
    o_pre = outs();
    x_pre = predict(cyc);
    tick();
    o_post = outs();
    x_post = predict(cyc);
    c_edge = cyc;
    for (int k = 2; k < vsw; k++) tick();
    v_sync = ~VS_POL;
    repeat (porch) tick();
    for (int l = 0; l < nl; l++) begin
      d_en = 1'b1;
      repeat ((l == bad_line) ? bad_w : w) tick();
      d_en = 1'b0;
      if (!(abut && l == nl - 1)) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    logic [26:0] o;
    n_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v_sync = 1'($urandom);
      d_en = 1'($urandom);
      tick();
      o = outs();
      total++;
      if (o !== 27'd0) begin
        bad++;
        $display("FAIL reset_outs cyc=%0d got=%h exp=0", cyc, o);
      end
    end
    v_sync = ~VS_POL;
    d_en = 1'b0;
    n_reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_stable();
    logic [26:0] op, xp, oq, xq;
    int ce;
    for (int i = 0; i < 5; i++) begin
      drive_frame(8, 16, -1, 0, 0, op, xp, oq, xq, ce);
      total += 2;
      if (op !== xp) begin
        bad++;
        $display("FAIL stable_pre f=%0d got=%h exp=%h", i, op, xp);
      end
      if (oq !== xq) begin
        bad++;
        $display("FAIL stable_post f=%0d got=%h exp=%h", i, oq, xq);
      end
      if (i >= 1) begin
        total++;
        if (oq[26:15] !== 12'd16 || oq[14:4] !== 11'd8 ||
            oq[3] !== (i >= 3) || oq[2:0] !== 3'b000) begin
          bad++;
          $display("FAIL stable_dir f=%0d got=%h w=16 l=8 v=%0d",
                   i, oq, (i >= 3));
        end
      end
    end
  endtask

  task automatic test_mismatch();
    logic [26:0] op, xp, oq, xq;
    int ce;
    drive_frame(8, 16, $urandom_range(1, 7), 15, 0, op, xp, oq, xq, ce);
    for (int i = 0; i < 4; i++) begin
      drive_frame(8, 16, -1, 0, 0, op, xp, oq, xq, ce);
      total++;
      if (oq !== xq) begin
        bad++;
        $display("FAIL mm_post f=%0d got=%h exp=%h", i, oq, xq);
      end
      if (i == 0 || i == 3) begin
        total++;
        if (oq[3] !== (i == 3) || oq[2] !== (i == 0)) begin
          bad++;
          $display("FAIL mm_dir f=%0d got v=%b mm=%b", i, oq[3], oq[2]);
        end
      end
    end
  endtask

  task automatic test_retime();
    logic [26:0] op, xp, oq, xq;
    int ce;
    for (int i = 0; i < 5; i++) begin
      drive_frame(6, 12, -1, 0, 0, op, xp, oq, xq, ce);
      total++;
      if (oq !== xq) begin
        bad++;
        $display("FAIL retime_post f=%0d got=%h exp=%h", i, oq, xq);
      end
      if (i == 1 || i == 4) begin
        total++;
        if (oq[26:15] !== 12'd12 || oq[14:4] !== 11'd6 ||
            oq[3] !== (i == 4)) begin
          bad++;
          $display("FAIL retime_dir f=%0d got=%h", i, oq);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [26:0] op, xp, oq, xq;
    int ce;
    drive_frame(6, 12, -1, 0, 0, op, xp, oq, xq, ce);
    while (cyc < ce + TO - 1) tick();
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL to_early got=%b exp=0", timeout);
    end
    tick();
    oq = outs();
    xq = predict(cyc);
    total += 2;
    if (oq !== 27'd1) begin
      bad++;
      $display("FAIL to_fire got=%h exp=1", oq);
    end
    if (oq !== xq) begin
      bad++;
      $display("FAIL to_model got=%h exp=%h", oq, xq);
    end
    drive_frame(8, 16, -1, 0, 0, op, xp, oq, xq, ce);
    total += 2;
    if (op !== xp) begin
      bad++;
      $display("FAIL to_pre got=%h exp=%h", op, xp);
    end
    if (oq !== 27'd0) begin
      bad++;
      $display("FAIL to_clear got=%h exp=0", oq);
    end
  endtask

  task automatic test_overflow();
    logic [26:0] o, x;
    for (int k = 0; k <= 5601; k++) begin
      v_sync = ((k % 700) < 3) ? VS_POL : ~VS_POL;
      d_en = (k >= 10 && k < 5010);
      tick();
      if (k % 700 == 1) begin
        o = outs();
        x = predict(cyc);
        total++;
        if (o !== x) begin
          bad++;
          $display("FAIL ovf_model k=%0d got=%h exp=%h", k, o, x);
        end
      end
    end
    o = outs();
    total++;
    if (o[26:15] !== 12'd4095 || o[14:4] !== 11'd1 ||
        o[1] !== 1'b1 || o[3] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_dir got=%h exp w=4095 l=1 ovf=1 v=0", o);
    end
    v_sync = ~VS_POL;
    d_en = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [26:0] op, xp, oq, xq;
    int ce, nl, w;
    nl = $urandom_range(2, 10);
    w = $urandom_range(4, 40);
    drive_frame(nl, w, -1, 0, 0, op, xp, oq, xq, ce);
    drive_frame(nl, w, -1, 0, 1, op, xp, oq, xq, ce);
    drive_frame(3, 9, -1, 0, 0, op, xp, oq, xq, ce);
    total += 2;
    if (oq !== xq) begin
      bad++;
      $display("FAIL same_model got=%h exp=%h", oq, xq);
    end
    if (oq[14:4] !== 11'(nl) || oq[26:15] !== 12'(w) || oq[2] !== 1'b0) begin
      bad++;
      $display("FAIL same_dir got=%h exp l=%0d w=%0d", oq, nl, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] op, xp, oq, xq;
    int ce, nl, w, bl;
    nl = 5;
    w = 20;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        nl = $urandom_range(0, 10);
        w = $urandom_range(1, 40);
      end
      bl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : -1;
      drive_frame(nl, w, bl, w + 1, 0, op, xp, oq, xq, ce);
      total += 2;
      if (op !== xp) begin
        bad++;
        $display("FAIL b2b_pre f=%0d got=%h exp=%h", i, op, xp);
      end
      if (oq !== xq) begin
        bad++;
        $display("FAIL b2b_post f=%0d got=%h exp=%h", i, oq, xq);
      end
    end
  endtask

  task automatic test_midreset();
    logic [26:0] op, xp, oq, xq;
    int ce;
    v_sync = VS_POL;
    repeat (3) tick();
    v_sync = ~VS_POL;
    d_en = 1'b1;
    repeat (10) tick();
    n_reset = 1'b0;
    repeat (3) tick();
    oq = outs();
    total++;
    if (oq !== 27'd0) begin
      bad++;
      $display("FAIL mid_rst got=%h exp=0", oq);
    end
    n_reset = 1'b1;
    d_en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_frame(7, 11, -1, 0, 0, op, xp, oq, xq, ce);
      total++;
      if (oq !== xq) begin
        bad++;
        $display("FAIL mid_post f=%0d got=%h exp=%h", i, oq, xq);
      end
      if (i == 0) begin
        total++;
        if (oq !== 27'd0) begin
          bad++;
          $display("FAIL mid_first got=%h exp=0", oq);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_mismatch();
    test_retime();
    test_timeout();
    test_overflow();
    test_same_cycle();
    test_back_to_back();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
